menu_nav: RTL and testbench

Parametrised on-screen menu controller that succeeds the fixed four-line menu overlay. It owns a CLOSED/OPEN/FLASH state machine and a wrap-around cursor over `N_ITEMS` rows, with button edge detection and hold-to-repeat. It renders the menu box, cursor highlight and confirm flash onto the VGA colour outputs, and reports the confirmed item with a one-cycle `sel_valid` pulse. Glyph pixels come from external `string_map` instances through `text_pix`; this block draws no text itself.

---
 rtl/menu_nav.sv | 203 ++++++++++++++++++++
 tb/tb_menu_nav.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/menu_nav.sv
// rtl/menu_nav.sv - parametrised on-screen menu controller with wrap cursor, auto-repeat and confirm flash
module menu_nav #(
  parameter int          N_ITEMS     = 4,
  parameter int          X0          = 50,
  parameter int          Y0          = 50,
  parameter int          WIDTH       = 200,
  parameter int          ROW_H       = 20,
  parameter int          PAD_Y       = 14,
  parameter int          REPEAT_DLY  = 8,
  parameter int          REPEAT_RATE = 3,
  parameter int          FLASH_TICKS = 4,
  parameter logic [11:0] BG_COLOR    = 12'h7CF,
  parameter logic [11:0] HL_COLOR    = 12'hA00,
  localparam int         IDX_W       = (N_ITEMS <= 2) ? 1 : $clog2(N_ITEMS)
) (
  input  logic               slow_clock,
  input  logic               reset,
  input  logic               btn_menu,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_select,
  input  logic [11:0]        VGA_HORZ_COORD,
  input  logic [11:0]        VGA_VERT_COORD,
  input  logic [N_ITEMS-1:0] text_pix,
  output logic               menu_open,
  output logic [IDX_W-1:0]   cursor,
  output logic [IDX_W-1:0]   sel_index,
  output logic               sel_valid,
  output logic               menu_bg,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue
);

  localparam logic [1:0] ST_CLOSED = 2'd0;
  localparam logic [1:0] ST_OPEN   = 2'd1;
  localparam logic [1:0] ST_FLASH  = 2'd2;

  localparam int HOLD_W  = (REPEAT_DLY <= 2) ? 1 : $clog2(REPEAT_DLY);
  localparam int FLASH_W = (FLASH_TICKS <= 2) ? 1 : $clog2(FLASH_TICKS);
  localparam int BOX_H   = 2 * PAD_Y + N_ITEMS * ROW_H;

  localparam logic [HOLD_W-1:0]  HOLD_TOP    = HOLD_W'(REPEAT_DLY - 1);
  localparam logic [HOLD_W-1:0]  HOLD_RELOAD = HOLD_W'(REPEAT_DLY - REPEAT_RATE);
  localparam logic [HOLD_W-1:0]  HOLD_ONE    = HOLD_W'(1);
  localparam logic [FLASH_W-1:0] FLASH_INIT  = FLASH_W'(FLASH_TICKS - 1);
  localparam logic [FLASH_W-1:0] FLASH_ONE   = FLASH_W'(1);
  localparam logic [IDX_W-1:0]   LAST_ROW    = IDX_W'(N_ITEMS - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE     = IDX_W'(1);
  localparam logic [N_ITEMS-1:0] ROW_ONE     = N_ITEMS'(1);

  // 13-bit compare domain so box edges near 4095 cannot overflow
  localparam logic [12:0] X_LO = 13'(X0);
  localparam logic [12:0] X_HI = 13'(X0 + WIDTH);
  localparam logic [12:0] Y_LO = 13'(Y0);
  localparam logic [12:0] Y_HI = 13'(Y0 + BOX_H);

  logic [1:0]         state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [FLASH_W-1:0] flash_cnt;
  logic               menu_q, up_q, down_q, select_q;

  logic rise_menu, rise_up, rise_down, rise_select;
  logic one_held, held_rise;
  logic [IDX_W-1:0] cursor_up, cursor_dn, cursor_step;

  assign rise_menu   = btn_menu & ~menu_q;
  assign rise_up     = btn_up & ~up_q;
  assign rise_down   = btn_down & ~down_q;
  assign rise_select = btn_select & ~select_q;

  // Exactly one direction held drives navigation; the rise belongs to that button
  assign one_held    = btn_up ^ btn_down;
  assign held_rise   = btn_up ? rise_up : rise_down;

  // Wrap modulo the row count, not the index width
  assign cursor_up   = (cursor == '0) ? LAST_ROW : cursor - IDX_ONE;
  assign cursor_dn   = (cursor == LAST_ROW) ? '0 : cursor + IDX_ONE;
  assign cursor_step = btn_up ? cursor_up : cursor_dn;

  // Button history for edge detection; resets high so a button held through reset never fires
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      menu_q   <= 1'b1;
      up_q     <= 1'b1;
      down_q   <= 1'b1;
      select_q <= 1'b1;
    end else begin
      menu_q   <= btn_menu;
      up_q     <= btn_up;
      down_q   <= btn_down;
      select_q <= btn_select;
    end
  end

  // Menu state machine, cursor navigation with hold-to-repeat, confirm flash
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      state     <= ST_CLOSED;
      cursor    <= '0;
      sel_index <= '0;
      sel_valid <= 1'b0;
      hold_cnt  <= '0;
      flash_cnt <= '0;
    end else begin
      sel_valid <= 1'b0;
      case (state)
        ST_CLOSED: begin
          hold_cnt <= '0;
          if (rise_menu) begin
            state  <= ST_OPEN;
            cursor <= sel_index;
          end
        end
        ST_OPEN: begin
          if (rise_menu) begin
            state    <= ST_CLOSED;
            hold_cnt <= '0;
          end else if (rise_select) begin
            state     <= ST_FLASH;
            flash_cnt <= FLASH_INIT;
            hold_cnt  <= '0;
          end else if (one_held) begin
            if (held_rise) begin
              cursor   <= cursor_step;
              hold_cnt <= '0;
            end else if (hold_cnt == HOLD_TOP) begin
              cursor   <= cursor_step;
              hold_cnt <= HOLD_RELOAD;
            end else begin
              hold_cnt <= hold_cnt + HOLD_ONE;
            end
          end else begin
            hold_cnt <= '0;
          end
        end
        ST_FLASH: begin
          hold_cnt <= '0;
          if (flash_cnt == '0) begin
            sel_index <= cursor;
            sel_valid <= 1'b1;
            state     <= ST_CLOSED;
          end else begin
            flash_cnt <= flash_cnt - FLASH_ONE;
          end
        end
        default: begin
          state    <= ST_CLOSED;
          hold_cnt <= '0;
        end
      endcase
    end
  end

  assign menu_open = (state == ST_OPEN) || (state == ST_FLASH);

  logic [12:0]        h, v;
  logic               in_box;
  logic [N_ITEMS-1:0] row_hit;
  logic [N_ITEMS-1:0] cursor_mask;
  logic               cur_row, cur_text, other_text, bar_lit;
  logic [11:0]        pix;

  assign h       = {1'b0, VGA_HORZ_COORD};
  assign v       = {1'b0, VGA_VERT_COORD};
  assign in_box  = (h > X_LO) && (h < X_HI) && (v > Y_LO) && (v < Y_HI);
  assign menu_bg = in_box && menu_open;

  // Vertical band of each row, clipped to the box
  always_comb begin
    row_hit = '0;
    for (int r = 0; r < N_ITEMS; r++) begin
      row_hit[r] = in_box && (v >= 13'(Y0 + PAD_Y + r * ROW_H))
                          && (v <  13'(Y0 + PAD_Y + (r + 1) * ROW_H));
    end
  end

  assign cursor_mask = ROW_ONE << cursor;
  assign cur_row     = |(row_hit & cursor_mask);
  assign cur_text    = |(row_hit & cursor_mask & text_pix);
  assign other_text  = |(row_hit & ~cursor_mask & text_pix);
  // Bar blinks on even flash counts; text inverts to black over the lit bar
  assign bar_lit     = (state == ST_FLASH) && !flash_cnt[0];

  // Pixel colour priority: closed, cursor text, other text, flash bar, box fill
  always_comb begin
    pix = 12'h000;
    if (!menu_open) begin
      pix = 12'h000;
    end else if (cur_text) begin
      pix = bar_lit ? 12'h000 : HL_COLOR;
    end else if (other_text) begin
      pix = 12'h000;
    end else if (cur_row && bar_lit) begin
      pix = HL_COLOR;
    end else if (in_box) begin
      pix = BG_COLOR;
    end
  end

  assign {red, green, blue} = pix;

endmodule

// File: tb/tb_menu_nav.sv
// tb/tb_menu_nav.sv - self-checking bench for menu_nav with directed scenarios and a reference model
module tb_menu_nav;

  localparam int N_ITEMS     = 4;
  localparam int X0          = 50;
  localparam int Y0          = 50;
  localparam int WIDTH       = 200;
  localparam int ROW_H       = 20;
  localparam int PAD_Y       = 14;
  localparam int REPEAT_DLY  = 8;
  localparam int REPEAT_RATE = 3;
  localparam int FLASH_TICKS = 4;
  localparam logic [11:0] BG = 12'h7CF;
  localparam logic [11:0] HL = 12'hA00;
  localparam int BOX_H = 2 * PAD_Y + N_ITEMS * ROW_H;

  localparam int M_CLOSED = 0;
  localparam int M_OPEN   = 1;
  localparam int M_FLASH  = 2;

  logic        slow_clock = 1'b0;
  logic        reset;
  logic        btn_menu, btn_up, btn_down, btn_select;
  logic [11:0] VGA_HORZ_COORD, VGA_VERT_COORD;
  logic [3:0]  text_pix;
  logic        menu_open;
  logic [1:0]  cursor;
  logic [1:0]  sel_index;
  logic        sel_valid;
  logic        menu_bg;
  logic [3:0]  red, green, blue;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int   m_state, m_cursor, m_sel, m_age, m_left;
  logic m_valid;
  logic m_pmenu, m_pup, m_pdown, m_psel;

  menu_nav dut (
    .slow_clock(slow_clock), .reset(reset),
    .btn_menu(btn_menu), .btn_up(btn_up), .btn_down(btn_down), .btn_select(btn_select),
    .VGA_HORZ_COORD(VGA_HORZ_COORD), .VGA_VERT_COORD(VGA_VERT_COORD),
    .text_pix(text_pix), .menu_open(menu_open), .cursor(cursor),
    .sel_index(sel_index), .sel_valid(sel_valid), .menu_bg(menu_bg),
    .red(red), .green(green), .blue(blue)
  );

  always #5 slow_clock = ~slow_clock;

  task automatic tick();
    @(posedge slow_clock);
    #1;
  endtask

  // Model: hold steps fall at held ages 0, DLY, DLY+RATE, ... counted from the rise
  task automatic model_step();
    logic r_menu, r_up, r_down, r_sel, r_held;
    int dir;
    r_menu = btn_menu & ~m_pmenu;
    r_up   = btn_up & ~m_pup;
    r_down = btn_down & ~m_pdown;
    r_sel  = btn_select & ~m_psel;
    m_valid = 1'b0;
    case (m_state)
      M_CLOSED: begin
        m_age = 0;
        if (r_menu) begin
          m_state  = M_OPEN;
          m_cursor = m_sel;
        end
      end
      M_OPEN: begin
        if (r_menu) begin
          m_state = M_CLOSED;
          m_age   = 0;
        end else if (r_sel) begin
          m_state = M_FLASH;
          m_left  = FLASH_TICKS;
          m_age   = 0;
        end else if (btn_up != btn_down) begin
          dir    = btn_up ? N_ITEMS - 1 : 1;
          r_held = btn_up ? r_up : r_down;
          if (r_held) begin
            m_cursor = (m_cursor + dir) % N_ITEMS;
            m_age    = 0;
          end else begin
            m_age++;
            if (m_age >= REPEAT_DLY && (m_age - REPEAT_DLY) % REPEAT_RATE == 0)
              m_cursor = (m_cursor + dir) % N_ITEMS;
          end
        end else begin
          m_age = 0;
        end
      end
      default: begin
        m_age = 0;
        m_left--;
        if (m_left == 0) begin
          m_sel   = m_cursor;
          m_valid = 1'b1;
          m_state = M_CLOSED;
        end
      end
    endcase
    m_pmenu = btn_menu;
    m_pup   = btn_up;
    m_pdown = btn_down;
    m_psel  = btn_select;
  endtask

  function automatic logic [11:0] exp_color(input int hc, input int vc, input logic [3:0] tp);
    int row;
    bit in_b, lit;
    in_b = (hc > X0) && (hc < X0 + WIDTH) && (vc > Y0) && (vc < Y0 + BOX_H);
    row = -1;
    if (in_b && vc >= Y0 + PAD_Y && vc < Y0 + PAD_Y + N_ITEMS * ROW_H)
      row = (vc - Y0 - PAD_Y) / ROW_H;
    lit = (m_state == M_FLASH) && ((m_left - 1) % 2 == 0);
    if (m_state == M_CLOSED) return 12'h000;
    if (row == m_cursor && tp[m_cursor]) return lit ? 12'h000 : HL;
    if (row >= 0 && tp[row]) return 12'h000;
    if (row == m_cursor && lit) return HL;
    if (in_b) return BG;
    return 12'h000;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    btn_up = 1'b1; btn_menu = 1'b1; btn_down = 1'b0; btn_select = 1'b0;
    VGA_HORZ_COORD = 12'd0; VGA_VERT_COORD = 12'd0; text_pix = 4'b0;
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (cursor !== 2'd0 || menu_open !== 1'b0 || sel_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold cyc=%0d cursor=%0d open=%b valid=%b want 0/0/0", i, cursor, menu_open, sel_valid);
      end
    end
  endtask

  task automatic test_open_wrap();
    btn_up = 1'b0; btn_menu = 1'b0;
    tick();
    btn_menu = 1'b1;
    tick();
    btn_menu = 1'b0;
    n_cmp++;
    if (menu_open !== 1'b1 || cursor !== 2'd0) begin
      n_err++;
      $display("FAIL open got open=%b cursor=%0d want 1/0", menu_open, cursor);
    end
    tick();
    btn_up = 1'b1;
    tick();
    btn_up = 1'b0;
    n_cmp++;
    if (cursor !== 2'd3) begin
      n_err++;
      $display("FAIL wrap_up got %0d want 3", cursor);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      btn_down = 1'b1;
      tick();
      btn_down = 1'b0;
      n_cmp++;
      if (cursor !== 2'(i)) begin
        n_err++;
        $display("FAIL wrap_down step %0d got %0d want %0d", i, cursor, i);
      end
      tick();
    end
  endtask

  task automatic test_autorepeat();
    int steps;
    btn_down = 1'b1;
    tick();
    btn_down = 1'b0;
    tick();
    n_cmp++;
    if (cursor !== 2'd0) begin
      n_err++;
      $display("FAIL repeat_start got %0d want 0", cursor);
    end
    btn_down = 1'b1;
    steps = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (k == 0 || k == 8 || k == 11 || k == 14) steps++;
      n_cmp++;
      if (cursor !== 2'(steps % N_ITEMS)) begin
        n_err++;
        $display("FAIL repeat held=%0d got %0d want %0d", k, cursor, steps % N_ITEMS);
      end
    end
    btn_down = 1'b0;
    tick();
    n_cmp++;
    if (cursor !== 2'd0) begin
      n_err++;
      $display("FAIL repeat_final got %0d want 0", cursor);
    end
  endtask

  task automatic test_confirm();
    int pulses;
    for (int i = 0; i < 2; i++) begin
      btn_down = 1'b1;
      tick();
      btn_down = 1'b0;
      tick();
    end
    n_cmp++;
    if (cursor !== 2'd2) begin
      n_err++;
      $display("FAIL confirm_setup got %0d want 2", cursor);
    end
    btn_select = 1'b1;
    tick();
    btn_select = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      if (sel_valid === 1'b1) pulses++;
      n_cmp++;
      if (sel_valid !== (i == 5)) begin
        n_err++;
        $display("FAIL confirm_valid cyc=%0d got %b want %b", i, sel_valid, (i == 5));
      end
      if (i == 5) begin
        n_cmp++;
        if (sel_index !== 2'd2 || menu_open !== 1'b0) begin
          n_err++;
          $display("FAIL confirm_pulse sel=%0d open=%b want 2/0", sel_index, menu_open);
        end
      end
      if (i <= 4) begin
        n_cmp++;
        if (menu_open !== 1'b1) begin
          n_err++;
          $display("FAIL confirm_flash_open cyc=%0d got %b want 1", i, menu_open);
        end
      end
      tick();
    end
    n_cmp++;
    if (pulses != 1) begin
      n_err++;
      $display("FAIL confirm_pulses got %0d want 1", pulses);
    end
    btn_menu = 1'b1;
    tick();
    btn_menu = 1'b0;
    n_cmp++;
    if (cursor !== 2'd2 || menu_open !== 1'b1) begin
      n_err++;
      $display("FAIL reopen cursor=%0d open=%b want 2/1", cursor, menu_open);
    end
    tick();
  endtask

  task automatic test_priority();
    btn_menu = 1'b1; btn_select = 1'b1; btn_up = 1'b1;
    tick();
    n_cmp++;
    if (menu_open !== 1'b0 || cursor !== 2'd2 || sel_valid !== 1'b0) begin
      n_err++;
      $display("FAIL priority open=%b cursor=%0d valid=%b want 0/2/0", menu_open, cursor, sel_valid);
    end
    btn_menu = 1'b0; btn_select = 1'b0; btn_up = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if (sel_valid !== 1'b0 || menu_open !== 1'b0) begin
        n_err++;
        $display("FAIL priority_after cyc=%0d valid=%b open=%b want 0/0", i, sel_valid, menu_open);
      end
    end
  endtask

  task automatic test_pixels();
    btn_menu = 1'b1;
    tick();
    btn_menu = 1'b0;
    tick();
    btn_up = 1'b1;
    tick();
    btn_up = 1'b0;
    tick();
    n_cmp++;
    if (cursor !== 2'd1) begin
      n_err++;
      $display("FAIL pix_setup cursor=%0d want 1", cursor);
    end
    VGA_HORZ_COORD = 12'd100; VGA_VERT_COORD = 12'd84; text_pix = 4'b0010;
    #1;
    n_cmp++;
    if ({red, green, blue} !== 12'hA00 || menu_bg !== 1'b1) begin
      n_err++;
      $display("FAIL pix_text rgb=%h bg=%b want a00/1", {red, green, blue}, menu_bg);
    end
    VGA_VERT_COORD = 12'd60; text_pix = 4'b0000;
    #1;
    n_cmp++;
    if ({red, green, blue} !== 12'h7CF) begin
      n_err++;
      $display("FAIL pix_fill rgb=%h want 7cf", {red, green, blue});
    end
    VGA_HORZ_COORD = 12'd300;
    #1;
    n_cmp++;
    if ({red, green, blue} !== 12'h000 || menu_bg !== 1'b0) begin
      n_err++;
      $display("FAIL pix_outside rgb=%h bg=%b want 000/0", {red, green, blue}, menu_bg);
    end
    VGA_HORZ_COORD = 12'd0; VGA_VERT_COORD = 12'd0;
  endtask

  task automatic test_reset_mid_flash();
    btn_select = 1'b1;
    tick();
    btn_select = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (menu_open !== 1'b0 || sel_valid !== 1'b0 || cursor !== 2'd0 || sel_index !== 2'd0) begin
      n_err++;
      $display("FAIL midflash_reset open=%b valid=%b cursor=%0d sel=%0d want 0/0/0/0",
               menu_open, sel_valid, cursor, sel_index);
    end
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (sel_valid !== 1'b0 || menu_open !== 1'b0) begin
        n_err++;
        $display("FAIL midflash_after cyc=%0d valid=%b open=%b want 0/0", i, sel_valid, menu_open);
      end
    end
  endtask

  task automatic test_random();
    int hc, vc;
    logic [11:0] exp_pix;
    bit exp_bg;
    reset = 1'b1;
    btn_menu = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_select = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    m_state = M_CLOSED; m_cursor = 0; m_sel = 0; m_age = 0; m_left = 0; m_valid = 1'b0;
    m_pmenu = 1'b1; m_pup = 1'b1; m_pdown = 1'b1; m_psel = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(15) == 0) btn_menu = ~btn_menu;
      if ($urandom_range(23) == 0) btn_select = ~btn_select;
      if ($urandom_range(9) == 0) btn_up = ~btn_up;
      if ($urandom_range(9) == 0) btn_down = ~btn_down;
      hc = int'($urandom_range(299));
      vc = 30 + int'($urandom_range(149));
      VGA_HORZ_COORD = 12'(hc);
      VGA_VERT_COORD = 12'(vc);
      text_pix = ($urandom_range(2) == 0) ? 4'($urandom_range(15)) : 4'b0000;
      #1;
      exp_pix = exp_color(hc, vc, text_pix);
      exp_bg  = (m_state != M_CLOSED) && (hc > X0) && (hc < X0 + WIDTH) && (vc > Y0) && (vc < Y0 + BOX_H);
      n_cmp++;
      if ({red, green, blue} !== exp_pix || menu_bg !== exp_bg) begin
        n_err++;
        $display("FAIL rand_pixel i=%0d h=%0d v=%0d tp=%b rgb=%h bg=%b want %h/%b",
                 i, hc, vc, text_pix, {red, green, blue}, menu_bg, exp_pix, exp_bg);
      end
      @(posedge slow_clock);
      model_step();
      #1;
      n_cmp++;
      if (menu_open !== (m_state != M_CLOSED) || cursor !== 2'(m_cursor) ||
          sel_index !== 2'(m_sel) || sel_valid !== m_valid) begin
        n_err++;
        $display("FAIL rand_state i=%0d open=%b cur=%0d sel=%0d valid=%b want %b/%0d/%0d/%b",
                 i, menu_open, cursor, sel_index, sel_valid,
                 (m_state != M_CLOSED), m_cursor, m_sel, m_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_open_wrap();
    test_autorepeat();
    test_confirm();
    test_priority();
    test_pixels();
    test_reset_mid_flash();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
